// File: rtl/chunked_addsub.sv
`default_nettype none
// ============================================================================
// Module      : chunked_addsub
// Description : Multi-cycle two's-complement adder/subtractor that processes
//               CHUNK bits per clock, LSB chunk first. Optional saturating
//               output is enabled by defining CHUNKED_ADDSUB_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic             r_a_msb;
    logic             r_b_msb;

    logic             w_accept;
    logic             w_last;
    logic [CHUNK:0]   w_chunk_total;
    logic [WIDTH-1:0] w_res_next;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sum_load;

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_idx == IDXW'(NCHUNK - 1));

    // Operands shift right each step so the active chunk always sits at bit 0;
    // the result fills in from the top and is complete after the last chunk.
    assign w_chunk_total = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                         + {{CHUNK{1'b0}}, r_carry};
    assign w_res_next    = (r_res >> CHUNK)
                         | (WIDTH'(w_chunk_total[CHUNK-1:0]) << (WIDTH - CHUNK));
    assign w_ovf         = (r_a_msb == r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);

`ifdef CHUNKED_ADDSUB_SATURATE_EN
    localparam logic [WIDTH-1:0] c_max_pos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

    assign w_sum_load = w_ovf ? (r_a_msb ? c_min_neg : c_max_pos) : w_res_next;
`else
    assign w_sum_load = w_res_next;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_idx     <= '0;
            r_a_msb   <= 1'b0;
            r_b_msb   <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b ^ {WIDTH{sub}};
                r_carry <= sub;
                r_idx   <= '0;
                r_res   <= '0;
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1] ^ sub;
            end else if (r_state == S_RUN) begin
                r_a     <= r_a >> CHUNK;
                r_b     <= r_b >> CHUNK;
                r_carry <= w_chunk_total[CHUNK];
                r_res   <= w_res_next;
                r_idx   <= r_idx + 1'b1;
                if (w_last) begin
                    sum       <= w_sum_load;
                    carry_out <= w_chunk_total[CHUNK];
                    overflow  <= w_ovf;
                end
            end
        end
    end

endmodule
`default_nettype wire
